booth_mult_sched: RTL

- Shares one Booth multiplier instance among NUM_REQ requesters.
- Round-robin arbitration. Valid/ready request handshake per requester.
- Sequences the multiplier through one start/done transaction per request.
- Returns the product tagged with the requester id. A timeout guard covers a multiplier that never reports done.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/booth_mult_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth multiplier scheduler
//
// Purpose: FSM state encoding, default operand width / timeout, product width helper.
// Ports:   none (package).
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_TIMEOUT = 16;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted request searching upward from rr_ptr with
//          wrap-around. The pointer itself is owned by the caller.
// Ports:
//   req      - request vector, one bit per requester
//   rr_ptr   - index the search starts from
//   enable   - when low no grant is issued
//   grant    - one-hot grant (all zero when nothing is granted)
//   grant_id - encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    int                 idx;
    logic [NUM_REQ-1:0] mask;
    logic               found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        mask     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap manually so non-power-of-two requester counts work too.
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            mask = NUM_REQ'(1) << idx;
            if (enable && !found && (|(req & mask))) begin
                found    = 1'b1;
                grant    = mask;
                grant_id = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/booth_mult_sched.sv
// rtl/booth_mult_sched.sv - shares one external Booth multiplier among NUM_REQ requesters
//
// Purpose: round-robin grants one request at a time, runs one start/done
//          transaction on the multiplier, returns the product tagged with the
//          requester id; a WAIT-state timeout answers with rsp_err if done never comes.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid / req_ready            - per-requester handshake (req_ready combinational)
//   req_multiplier/req_multiplicand  - packed signed operands, slice [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready              - response handshake
//   rsp_id, rsp_result, rsp_err      - answered requester, product, timeout flag
//   mul_start, mul_multiplier,
//   mul_multiplicand                 - request side of the external multiplier
//   mul_done, mul_result             - completion side of the external multiplier
module booth_mult_sched
    import booth_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
    input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_err,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplier,
    output logic [WIDTH-1:0]         mul_multiplicand,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_result
);

    localparam int PROD_W = prod_width(WIDTH);
    localparam int CNT_W  = $clog2(TIMEOUT) + 1;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic                rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_d;
    logic [PROD_W-1:0]   rsp_result_d;
    logic                rsp_err_d;
    logic                mul_start_d;
    logic [WIDTH-1:0]    mplr_d, mcnd_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                arb_en;
    logic                handshake;
    logic [WIDTH-1:0]    sel_mplr, sel_mcnd;

    // No grant while busy or while reset is being applied.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_q),
        .enable   (arb_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // The grant only ever selects a valid requester, so a grant is a handshake.
    assign req_ready = grant;
    assign handshake = |grant;

    assign sel_mplr = WIDTH'(req_multiplier   >> (int'(grant_id) * WIDTH));
    assign sel_mcnd = WIDTH'(req_multiplicand >> (int'(grant_id) * WIDTH));

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        tmo_cnt_d    = tmo_cnt_q;
        rsp_valid_d  = rsp_valid;
        rsp_id_d     = rsp_id;
        rsp_result_d = rsp_result;
        rsp_err_d    = rsp_err;
        mul_start_d  = 1'b0;
        mplr_d       = mul_multiplier;
        mcnd_d       = mul_multiplicand;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    mplr_d      = sel_mplr;
                    mcnd_d      = sel_mcnd;
                    rsp_id_d    = grant_id;
                    rr_ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    // Registered, so the pulse lands exactly on the ISSUE cycle.
                    mul_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // done is checked first so it wins over a same-cycle timeout.
                if (mul_done) begin
                    rsp_result_d = mul_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            rr_ptr_q         <= '0;
            tmo_cnt_q        <= '0;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_result       <= '0;
            rsp_err          <= 1'b0;
            mul_start        <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            tmo_cnt_q        <= tmo_cnt_d;
            rsp_valid        <= rsp_valid_d;
            rsp_id           <= rsp_id_d;
            rsp_result       <= rsp_result_d;
            rsp_err          <= rsp_err_d;
            mul_start        <= mul_start_d;
            mul_multiplier   <= mplr_d;
            mul_multiplicand <= mcnd_d;
        end
    end

endmodule
